mem_wb_pipe: RTL and testbench

MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

---
 rtl/mem_wb_pkg.sv | 14 +
 rtl/mem_wb_pipe_skid.sv | 87 ++++++++
 rtl/mem_wb_pipe.sv | 52 +++++
 tb/tb_mem_wb_pipe.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared defaults and beat layout for the MEM/WB pipeline register.
package mem_wb_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int RD_W_DEF   = 4;

  // Field order matches the flat {result, rd, reg_write} packing used by the top.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] result;
    logic [RD_W_DEF-1:0]   rd;
    logic                  reg_write;
  } beat_t;

  localparam int BEAT_W_DEF = $bits(beat_t);
endpackage

// File: rtl/mem_wb_pipe_skid.sv
// Entry storage and ready logic for the MEM/WB register; two-entry registered-ready
// skid buffer when MEM_WB_SKID_EN is defined, single entry otherwise.
module wb_skid_buffer #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);
  logic         main_vld_p0;
  logic [W-1:0] main_p0;
  logic         accept;
  logic         drain;

  assign drain = main_vld_p0 & out_ready;

`ifdef MEM_WB_SKID_EN
  logic         skid_vld_p0;
  logic [W-1:0] skid_p0;

  // skid_vld_p0 is a flop, so in_ready never sees out_ready combinationally.
  assign in_ready = ~skid_vld_p0;
  assign accept   = in_valid & in_ready & ~flush;

  // ---- stage p0: main/skid entries ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_vld_p0 <= 1'b0;
      skid_vld_p0 <= 1'b0;
      main_p0     <= '0;
      skid_p0     <= '0;
    end else if (flush) begin
      main_vld_p0 <= 1'b0;
      skid_vld_p0 <= 1'b0;
    end else if (drain) begin
      if (skid_vld_p0) begin
        main_p0     <= skid_p0;
        skid_vld_p0 <= 1'b0;
      end else if (accept) begin
        main_p0 <= in_data;
      end else begin
        main_vld_p0 <= 1'b0;
      end
    end else if (accept) begin
      if (main_vld_p0) begin
        skid_p0     <= in_data;
        skid_vld_p0 <= 1'b1;
      end else begin
        main_p0     <= in_data;
        main_vld_p0 <= 1'b1;
      end
    end
  end

  assign occupancy = {1'b0, main_vld_p0} + {1'b0, skid_vld_p0};
`else
  assign in_ready = out_ready | ~main_vld_p0;
  assign accept   = in_valid & in_ready & ~flush;

  // ---- stage p0: single entry ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_vld_p0 <= 1'b0;
      main_p0     <= '0;
    end else if (flush) begin
      main_vld_p0 <= 1'b0;
    end else if (accept) begin
      main_p0     <= in_data;
      main_vld_p0 <= 1'b1;
    end else if (drain) begin
      main_vld_p0 <= 1'b0;
    end
  end

  assign occupancy = {1'b0, main_vld_p0};
`endif

  assign out_valid = main_vld_p0;
  assign out_data  = main_p0;
endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with valid/ready handshake and WB forwarding outputs.
// Define MEM_WB_SKID_EN for the two-entry registered-ready variant.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_reg_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_reg_write,
  output logic              wb_fwd_valid,
  output logic [DATA_W-1:0] wb_forwarded_data,
  output logic [1:0]        occupancy
);
  localparam int BW = DATA_W + RD_W + 1;

  logic [BW-1:0] in_beat;
  logic [BW-1:0] head;

  assign in_beat = {in_result, in_rd, in_reg_write};

  wb_skid_buffer #(.W(BW)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_beat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head),
    .occupancy (occupancy)
  );

  // Fields read as zero whenever no beat is presented.
  assign out_result        = out_valid ? head[BW-1 -: DATA_W] : '0;
  assign out_rd            = out_valid ? head[RD_W:1] : '0;
  assign out_reg_write     = out_valid & head[0];
  assign wb_fwd_valid      = out_valid & out_reg_write;
  assign wb_forwarded_data = wb_fwd_valid ? out_result : '0;
endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: vector table plus hand sequences for multi-cycle cases.
module tb_mem_wb_pipe;
  import mem_wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_reg_write;
  logic        out_valid, out_ready, out_reg_write, wb_fwd_valid;
  logic [31:0] in_result, out_result, wb_forwarded_data;
  logic [3:0]  in_rd, out_rd;
  logic [1:0]  occupancy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_wb_pipe dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_result         (in_result),
    .in_rd             (in_rd),
    .in_reg_write      (in_reg_write),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_result        (out_result),
    .out_rd            (out_rd),
    .out_reg_write     (out_reg_write),
    .wb_fwd_valid      (wb_fwd_valid),
    .wb_forwarded_data (wb_forwarded_data),
    .occupancy         (occupancy)
  );

  typedef struct {
    logic        flush;
    logic        vld;
    beat_t       b;
    logic        ordy;
    logic        ov;
    logic [31:0] eres;
    logic [3:0]  erd;
    logic        erw;
    logic        efv;
    logic [31:0] efd;
    logic [1:0]  eocc;
    logic        erdy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic v, input logic [31:0] r,
                       input logic [3:0] d, input logic w, input logic o);
    flush        = f;
    in_valid     = v;
    in_result    = r;
    in_rd        = d;
    in_reg_write = w;
    out_ready    = o;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic [31:0] res,
                         input logic [3:0] rd, input logic rw, input logic fv,
                         input logic [31:0] fd, input logic [1:0] occ, input logic rdy);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, ov});
    chk({tag, ".out_result"}, out_result, res);
    chk({tag, ".out_rd"}, {28'b0, out_rd}, {28'b0, rd});
    chk({tag, ".out_reg_write"}, {31'b0, out_reg_write}, {31'b0, rw});
    chk({tag, ".wb_fwd_valid"}, {31'b0, wb_fwd_valid}, {31'b0, fv});
    chk({tag, ".wb_forwarded_data"}, wb_forwarded_data, fd);
    chk({tag, ".occupancy"}, {30'b0, occupancy}, {30'b0, occ});
    chk({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, rdy});
  endtask

`ifndef MEM_WB_SKID_EN
  vec_t vecs[10];
`endif

  initial begin
    reset = 1'b0;
    drive(0, 0, 32'h0, 4'h0, 0, 0);
    #2;
    chk_all("rst", 0, 32'h0, 4'h0, 0, 0, 32'h0, 2'd0, 1);
    #20;
    @(negedge clk);
    reset = 1'b1;

`ifndef MEM_WB_SKID_EN
    //          flush vld  {result, rd, rw}           ordy ov eres           erd  erw efv efd           occ rdy
    vecs[0] = '{0, 1, '{32'h0000_00AA, 4'd3,  1'b1}, 1, 1, 32'h0000_00AA, 4'd3,  1, 1, 32'h0000_00AA, 2'd1, 1};
    vecs[1] = '{0, 1, '{32'hDEAD_BEEF, 4'd5,  1'b0}, 1, 1, 32'hDEAD_BEEF, 4'd5,  0, 0, 32'h0,         2'd1, 1};
    vecs[2] = '{0, 1, '{32'h0000_0011, 4'd7,  1'b1}, 0, 1, 32'hDEAD_BEEF, 4'd5,  0, 0, 32'h0,         2'd1, 0};
    vecs[3] = '{0, 1, '{32'h0000_0011, 4'd7,  1'b1}, 1, 1, 32'h0000_0011, 4'd7,  1, 1, 32'h0000_0011, 2'd1, 1};
    vecs[4] = '{0, 0, '{32'h0000_0000, 4'd0,  1'b0}, 1, 0, 32'h0,         4'd0,  0, 0, 32'h0,         2'd0, 1};
    vecs[5] = '{0, 1, '{32'h0000_0022, 4'd1,  1'b1}, 0, 1, 32'h0000_0022, 4'd1,  1, 1, 32'h0000_0022, 2'd1, 0};
    vecs[6] = '{1, 1, '{32'h0000_0055, 4'd2,  1'b1}, 0, 0, 32'h0,         4'd0,  0, 0, 32'h0,         2'd0, 1};
    vecs[7] = '{0, 0, '{32'h0000_0000, 4'd0,  1'b0}, 1, 0, 32'h0,         4'd0,  0, 0, 32'h0,         2'd0, 1};
    vecs[8] = '{0, 1, '{32'h0000_0033, 4'd15, 1'b1}, 0, 1, 32'h0000_0033, 4'd15, 1, 1, 32'h0000_0033, 2'd1, 0};
    vecs[9] = '{1, 0, '{32'h0000_0000, 4'd0,  1'b0}, 1, 0, 32'h0,         4'd0,  0, 0, 32'h0,         2'd0, 1};

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].flush, vecs[i].vld, vecs[i].b.result, vecs[i].b.rd,
            vecs[i].b.reg_write, vecs[i].ordy);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].eres, vecs[i].erd, vecs[i].erw,
              vecs[i].efv, vecs[i].efd, vecs[i].eocc, vecs[i].erdy);
    end

    // out_ready toggling 1,0,1 under continuous in_valid
    drive(0, 1, 32'h100, 4'd1, 1, 1);
    tick();
    chk("tog.res0", out_result, 32'h100);
    chk("tog.rdy0", {31'b0, in_ready}, 32'd1);
    drive(0, 1, 32'h101, 4'd2, 1, 0);
    #1;
    chk("tog.rdy_comb_lo", {31'b0, in_ready}, 32'd0);
    tick();
    chk("tog.res_hold", out_result, 32'h100);
    chk("tog.occ_hold", {30'b0, occupancy}, 32'd1);
    drive(0, 1, 32'h101, 4'd2, 1, 1);
    #1;
    chk("tog.rdy_comb_hi", {31'b0, in_ready}, 32'd1);
    tick();
    chk("tog.res1", out_result, 32'h101);
    chk("tog.occ1", {30'b0, occupancy}, 32'd1);
    drive(0, 0, 32'h0, 4'd0, 0, 1);
    tick();
    chk("tog.occ_empty", {30'b0, occupancy}, 32'd0);
`else
    // three beats offered with out_ready low: only two fit
    drive(0, 1, 32'h1, 4'd1, 1, 0);
    tick();
    chk_all("skid.b1", 1, 32'h1, 4'd1, 1, 1, 32'h1, 2'd1, 1);
    drive(0, 1, 32'h2, 4'd2, 1, 0);
    tick();
    chk_all("skid.b2", 1, 32'h1, 4'd1, 1, 1, 32'h1, 2'd2, 0);
    drive(0, 1, 32'h3, 4'd3, 1, 0);
    tick();
    chk_all("skid.b3_blk", 1, 32'h1, 4'd1, 1, 1, 32'h1, 2'd2, 0);
    drive(0, 1, 32'h3, 4'd3, 1, 1);
    tick();
    chk_all("skid.dr1", 1, 32'h2, 4'd2, 1, 1, 32'h2, 2'd1, 1);
    tick();
    chk_all("skid.dr2", 1, 32'h3, 4'd3, 1, 1, 32'h3, 2'd1, 1);
    drive(0, 0, 32'h0, 4'd0, 0, 1);
    tick();
    chk_all("skid.dr3", 0, 32'h0, 4'd0, 0, 0, 32'h0, 2'd0, 1);

    // flush while full, with a beat offered in the same cycle
    drive(0, 1, 32'h10, 4'd4, 1, 0);
    tick();
    drive(0, 1, 32'h11, 4'd5, 1, 0);
    tick();
    chk("fl.occ2", {30'b0, occupancy}, 32'd2);
    drive(1, 1, 32'h55, 4'd6, 1, 0);
    tick();
    chk_all("fl.clr", 0, 32'h0, 4'd0, 0, 0, 32'h0, 2'd0, 1);
    drive(0, 0, 32'h0, 4'd0, 0, 1);
    tick();
    chk_all("fl.no55", 0, 32'h0, 4'd0, 0, 0, 32'h0, 2'd0, 1);
`endif

    // reset asserted between edges with one beat held
    drive(0, 1, 32'h77, 4'd4, 1, 0);
    tick();
    chk("ar.occ_pre", {30'b0, occupancy}, 32'd1);
    chk("ar.ov_pre", {31'b0, out_valid}, 32'd1);
    drive(0, 0, 32'h0, 4'd0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_all("ar.async", 0, 32'h0, 4'd0, 0, 0, 32'h0, 2'd0, 1);
    #2;
    reset = 1'b1;
    tick();
    chk_all("ar.after", 0, 32'h0, 4'd0, 0, 0, 32'h0, 2'd0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
